// File: rtl/fifo_push_arbiter.sv
// Round-robin scheduler for the single push port of the 2-entry async FIFO.
// Accepts only when full is low and the post-push gap has expired.
module fifo_push_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int PUSH_GAP = 1,
  parameter int CNT_W    = 16
) (
  input  logic                        wclk,
  input  logic                        reset_w_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        full,
  output logic                        push,
  output logic [DATA_W-1:0]           push_data,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        gap_active,
  output logic [CNT_W-1:0]            push_cnt
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int GAP_W = (PUSH_GAP > 0) ? $clog2(PUSH_GAP + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    GAP
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   winner;
  logic              found;
  logic              accept;
  logic [GAP_W-1:0]  gap_cnt;
  int                idx;

  // Search starts one past the last winner so every requester gets its turn.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[ID_W-1:0];
      end
    end
  end

  // Gated by reset so no strobe escapes while the block is held in reset.
  assign accept = reset_w_n && !full && (gap_cnt == '0) && found;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[winner] = 1'b1;
    end
  end

  always_ff @(posedge wclk or negedge reset_w_n) begin
    if (!reset_w_n) begin
      push      <= 1'b0;
      push_data <= '0;
      grant_id  <= '0;
      push_cnt  <= '0;
      ptr       <= ID_W'(NUM_REQ - 1);
      gap_cnt   <= '0;
      state     <= IDLE;
    end else begin
      push <= accept;
      if (accept) begin
        push_data <= req_data[int'(winner)*DATA_W +: DATA_W];
        grant_id  <= winner;
        ptr       <= winner;
        push_cnt  <= push_cnt + CNT_W'(1);
        gap_cnt   <= GAP_W'(PUSH_GAP);
        state     <= (PUSH_GAP > 0) ? GAP : ACCEPT;
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
        state   <= (gap_cnt == GAP_W'(1)) ? IDLE : GAP;
      end else begin
        state <= IDLE;
      end
    end
  end

  // GAP is entered and left in lockstep with the gap counter being nonzero.
  assign gap_active = (state == GAP);

  push_after_not_full: assert property (
    @(posedge wclk) disable iff (!reset_w_n) push |-> $past(!full)
  );

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter: two instances (PUSH_GAP=0 and 2) share stimulus,
// a reference model feeds a per-instance scoreboard of expected pushes.
module tb_fifo_push_arbiter;

  logic        wclk = 1'b0;
  logic        reset_w_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic        full;

  logic [3:0]  req_ready_o  [2];
  logic        push_o       [2];
  logic [7:0]  push_data_o  [2];
  logic [1:0]  grant_id_o   [2];
  logic        gap_active_o [2];
  logic [15:0] push_cnt_o   [2];

  always #5 wclk = ~wclk;

  fifo_push_arbiter #(.NUM_REQ(4), .DATA_W(8), .PUSH_GAP(0), .CNT_W(16)) dut_g0 (
    .wclk(wclk), .reset_w_n(reset_w_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready_o[0]), .full(full), .push(push_o[0]), .push_data(push_data_o[0]),
    .grant_id(grant_id_o[0]), .gap_active(gap_active_o[0]), .push_cnt(push_cnt_o[0])
  );

  fifo_push_arbiter #(.NUM_REQ(4), .DATA_W(8), .PUSH_GAP(2), .CNT_W(16)) dut_g2 (
    .wclk(wclk), .reset_w_n(reset_w_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready_o[1]), .full(full), .push(push_o[1]), .push_data(push_data_o[1]),
    .grant_id(grant_id_o[1]), .gap_active(gap_active_o[1]), .push_cnt(push_cnt_o[1])
  );

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [3:0] valid;
    logic       full;
    logic [3:0] ready;
  } vec_t;

  exp_t        sbq0[$];
  exp_t        sbq1[$];
  vec_t        vecs[$];
  int          m_ptr   [2];
  int          m_gap   [2];
  int          gap_cfg [2];
  logic [15:0] m_cnt   [2];
  logic        prev_full;
  int          checks   = 0;
  int          failures = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int j = 0; j < 2; j++) begin
      m_ptr[j] = 3;
      m_gap[j] = 0;
      m_cnt[j] = '0;
    end
    sbq0.delete();
    sbq1.delete();
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic f);
    req_valid = v;
    full      = f;
  endtask

  // Called at the negedge: retire last cycle's expected push, predict this cycle.
  task automatic checkOutput(input logic chk, input logic [3:0] exp_rdy);
    for (int j = 0; j < 2; j++) begin
      exp_t       e;
      logic       have;
      logic       acc;
      int         win;
      int         idx;
      logic [3:0] exp_ready;
      have = (j == 0) ? (sbq0.size() != 0) : (sbq1.size() != 0);
      cmp($sformatf("push[%0d]", j), push_o[j], have);
      if (have) begin
        e = (j == 0) ? sbq0.pop_front() : sbq1.pop_front();
        if (push_o[j]) begin
          cmp($sformatf("grant_id[%0d]", j), grant_id_o[j], e.id);
          cmp($sformatf("push_data[%0d]", j), push_data_o[j], e.data);
          cmp($sformatf("push_after_full[%0d]", j), prev_full, 1'b0);
        end
      end
      acc = 1'b0;
      win = 0;
      if (reset_w_n && !full && m_gap[j] == 0) begin
        for (int k = 1; k <= 4; k++) begin
          idx = (m_ptr[j] + k) % 4;
          if (!acc && req_valid[idx]) begin
            acc = 1'b1;
            win = idx;
          end
        end
      end
      exp_ready = acc ? (4'b0001 << win) : 4'b0000;
      cmp($sformatf("req_ready[%0d]", j), req_ready_o[j], exp_ready);
      cmp($sformatf("gap_active[%0d]", j), gap_active_o[j], m_gap[j] != 0);
      cmp($sformatf("push_cnt[%0d]", j), push_cnt_o[j], m_cnt[j]);
      if (acc) begin
        e.id   = 2'(win);
        e.data = req_data[win*8 +: 8];
        if (j == 0) sbq0.push_back(e);
        else        sbq1.push_back(e);
      end
      if (!reset_w_n) begin
        m_ptr[j] = 3;
        m_gap[j] = 0;
        m_cnt[j] = '0;
      end else if (acc) begin
        m_ptr[j] = win;
        m_gap[j] = gap_cfg[j];
        m_cnt[j] = m_cnt[j] + 16'd1;
      end else if (m_gap[j] > 0) begin
        m_gap[j] = m_gap[j] - 1;
      end
    end
    if (chk) cmp("table_ready", req_ready_o[0], exp_rdy);
    prev_full = full;
  endtask

  task automatic runCycle(input logic [3:0] v, input logic f, input logic chk, input logic [3:0] exp_rdy);
    applyStimulus(v, f);
    @(negedge wclk);
    checkOutput(chk, exp_rdy);
    @(posedge wclk);
    #2;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    gap_cfg[0] = 0;
    gap_cfg[1] = 2;
    reset_w_n  = 1'b0;
    prev_full  = 1'b0;
    applyStimulus(4'hF, 1'b0);
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'hA0 + 8'(i);
    modelReset();

    // Expected req_ready for the PUSH_GAP=0 instance, hand-derived.
    vecs.push_back('{4'hF, 1'b0, 4'b0001});
    vecs.push_back('{4'hF, 1'b0, 4'b0010});
    vecs.push_back('{4'hF, 1'b0, 4'b0100});
    vecs.push_back('{4'hF, 1'b0, 4'b1000});
    vecs.push_back('{4'hF, 1'b0, 4'b0001});
    vecs.push_back('{4'h0, 1'b0, 4'b0000});
    for (int i = 0; i < 5; i++) vecs.push_back('{4'b0100, 1'b1, 4'b0000});
    vecs.push_back('{4'b0100, 1'b0, 4'b0100});
    vecs.push_back('{4'h0, 1'b0, 4'b0000});
    vecs.push_back('{4'h0, 1'b0, 4'b0000});
    vecs.push_back('{4'b0010, 1'b1, 4'b0000});
    vecs.push_back('{4'b0010, 1'b0, 4'b0010});
    vecs.push_back('{4'h0, 1'b0, 4'b0000});
    for (int i = 0; i < 3; i++) vecs.push_back('{4'b1000, 1'b0, 4'b1000});
    vecs.push_back('{4'h0, 1'b0, 4'b0000});

    @(posedge wclk);
    #2;
    for (int i = 0; i < 3; i++) runCycle(4'hF, 1'b0, 1'b1, 4'b0000);
    reset_w_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      runCycle(vecs[i].valid, vecs[i].full, 1'b1, vecs[i].ready);
    end
    cmp("table_push_cnt", push_cnt_o[0], 16'd10);

    for (int i = 0; i < 3; i++) runCycle(4'h0, 1'b0, 1'b1, 4'b0000);
    for (int k = 0; k < 9; k++) begin
      applyStimulus(4'hF, 1'b0);
      @(negedge wclk);
      cmp("gap_push_pattern", push_o[1], (k % 3) == 1);
      cmp("gap_active_pattern", gap_active_o[1], (k % 3) != 0);
      checkOutput(1'b0, 4'b0000);
      @(posedge wclk);
      #2;
    end

    cmp("pre_reset_push", push_o[0], 1'b1);
    reset_w_n = 1'b0;
    #1;
    cmp("async_reset_push0", push_o[0], 1'b0);
    cmp("async_reset_push1", push_o[1], 1'b0);
    cmp("async_reset_cnt0", push_cnt_o[0], 16'd0);
    cmp("async_reset_ready0", req_ready_o[0], 4'b0000);
    modelReset();
    runCycle(4'hF, 1'b0, 1'b1, 4'b0000);
    reset_w_n = 1'b1;
    runCycle(4'hF, 1'b0, 1'b1, 4'b0001);
    runCycle(4'h0, 1'b0, 1'b1, 4'b0000);
    cmp("post_reset_cnt0", push_cnt_o[0], 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
